// File: rtl/priority_encoder_irq.sv
// Sequential priority encoder for the interrupt/request path: captures request edges,
// presents the highest pending index until acknowledged, then retires that request.
module priority_encoder_irq #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [(2**WIDTH)-1:0]   D,
  input  logic                    EN,
  input  logic                    ACK,
  input  logic                    CLR_OVR,
  output logic [WIDTH-1:0]        S,
  output logic                    VALID,
  output logic [(2**WIDTH)-1:0]   PENDING,
  output logic                    OVR
);

  localparam int unsigned N = 2**WIDTH;

  typedef enum logic {StIdle, StPresent} state_e;

  state_e           r_state;
  logic [N-1:0]     r_d_prev;
  logic [N-1:0]     r_rise;
  logic [N-1:0]     r_pending;
  logic [WIDTH-1:0] r_s;
  logic             r_valid;
  logic             r_ovr;

  logic [N-1:0]     w_rise;
  logic [N-1:0]     w_cap;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_pending_d;
  logic [WIDTH-1:0] w_top;
  logic             w_any;
  logic             w_ovr_d;
  logic             w_ack_present;

  assign w_rise        = D & ~r_d_prev;
  assign w_cap         = EN ? r_rise : '0;
  assign w_ack_present = (r_state == StPresent) && ACK;

  // Upward scan: the last set bit seen is the highest index, which wins.
  always_comb begin
    w_top = '0;
    w_any = 1'b0;
    w_clr = '0;
    for (int i = 0; i < N; i++) begin
      if (r_pending[i]) begin
        w_top = i[WIDTH-1:0];
        w_any = 1'b1;
      end
      w_clr[i] = w_ack_present && (r_s == i[WIDTH-1:0]);
    end
  end

  // A fresh capture overrides a same-cycle retire of the same line.
  assign w_pending_d = (r_pending & ~w_clr) | w_cap;
  assign w_ovr_d     = (|(w_cap & r_pending)) | (r_ovr & ~CLR_OVR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_d_prev  <= '0;
      r_rise    <= '0;
      r_pending <= '0;
      r_s       <= '0;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_d_prev  <= D;
      r_rise    <= w_rise;
      r_pending <= w_pending_d;
      r_ovr     <= w_ovr_d;
      unique case (r_state)
        StIdle: begin
          if (EN && w_any) begin
            r_s     <= w_top;
            r_valid <= 1'b1;
            r_state <= StPresent;
          end
        end
        StPresent: begin
          if (ACK) begin
            r_valid <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign S       = r_s;
  assign VALID   = r_valid;
  assign PENDING = r_pending;
  assign OVR     = r_ovr;

endmodule
